controle_multiciclo: RTL and testbench

- Multicycle control unit for the RV64I-subset processor. Sequences fetch, decode, execute, memory and writeback over the shared single-ALU datapath.
- Decodes the opcode and funct fields from the instruction register. Drives every datapath write strobe, mux select and ALU operation.
- Stretches memory states by a programmable latency.
- Replaces the fixed four-state sequencer at the top of the CPU.

---
 rtl/controle_multiciclo.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_controle_multiciclo.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_multiciclo.sv
// rtl/controle_multiciclo.sv - multicycle control unit for the RV64I-subset datapath
//
// Sequences fetch/decode/execute/memory/writeback over the shared single-ALU
// datapath and drives every write strobe, mux select and ALU operation.
// Memory-access states (FETCH, MEM_READ, MEM_WRITE) are held for MEM_LAT
// cycles each.
//
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   opcode/funct3/funct7b5  instruction fields from IR
//   zero                ALU zero flag (combinational, used in BRANCH)
//   reset_wire          datapath register reset (RESET state only)
//   operacao            ALU operation select
//   ALU_SRC_A/B         ALU operand mux selects
//   WRITE_PC, PC_SRC    PC load and PC source select
//   MEM_INSTR_RD, WRITE_INSTRUCTION  instruction fetch and IR load
//   WRITE_AB, WRITE_ALUOUT           operand and ALUOut register loads
//   MEM_DATA_RD, MEM_DATA_WR, WRITE_MDR  data memory access and MDR load
//   REG_WRITE, MEM_TO_REG            register-file write and source select
//   trap                illegal-instruction flag (held until RST)
//   estado_atual        current state code
module controle_multiciclo #(
    parameter int MEM_LAT = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       reset_wire,
    output logic [2:0] operacao,
    output logic [1:0] ALU_SRC_A,
    output logic [1:0] ALU_SRC_B,
    output logic       WRITE_PC,
    output logic       PC_SRC,
    output logic       MEM_INSTR_RD,
    output logic       WRITE_INSTRUCTION,
    output logic       WRITE_AB,
    output logic       WRITE_ALUOUT,
    output logic       MEM_DATA_RD,
    output logic       MEM_DATA_WR,
    output logic       WRITE_MDR,
    output logic       REG_WRITE,
    output logic [1:0] MEM_TO_REG,
    output logic       trap,
    output logic [3:0] estado_atual
);

    // A latency of 0 is treated as 1; the counter is 4 bits wide.
    localparam int LAT_EFF = (MEM_LAT < 1) ? 1 : ((MEM_LAT > 15) ? 15 : MEM_LAT);
    localparam logic [3:0] LAST_CNT = 4'(LAT_EFF - 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_XOR  = 3'b101;
    localparam logic [2:0] ALU_SLT  = 3'b110;

    typedef enum logic [3:0] {
        S_RESET     = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_EXEC_R    = 4'd3,
        S_EXEC_I    = 4'd4,
        S_ADDR      = 4'd5,
        S_MEM_READ  = 4'd6,
        S_MEM_WRITE = 4'd7,
        S_WB_ALU    = 4'd8,
        S_WB_MEM    = 4'd9,
        S_BRANCH    = 4'd10,
        S_JAL       = 4'd11,
        S_LUI       = 4'd12,
        S_PC_INC    = 4'd13,
        S_TRAP      = 4'd14
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] wait_cnt;
    logic       mem_state;
    logic       last;
    logic       f3_legal;
    logic [2:0] f3_op;
    logic [2:0] r_op;
    logic       br_legal;
    logic       br_taken;

    assign mem_state = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
    assign last      = (wait_cnt == LAST_CNT);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_RESET;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_next;
            // Counter runs only while a memory state is being held, so it is
            // 0 again on entry to whichever state follows.
            wait_cnt <= (mem_state && !last) ? wait_cnt + 4'd1 : 4'd0;
        end
    end

    // funct3 to ALU op shared by EXEC_R and EXEC_I; only R-type honours funct7b5.
    always_comb begin
        f3_legal = 1'b1;
        f3_op    = ALU_ADD;
        case (funct3)
            3'b000:  f3_op = ALU_ADD;
            3'b111:  f3_op = ALU_AND;
            3'b110:  f3_op = ALU_OR;
            3'b100:  f3_op = ALU_XOR;
            3'b010:  f3_op = ALU_SLT;
            default: begin
                f3_legal = 1'b0;
                f3_op    = ALU_PASS;
            end
        endcase
    end

    assign r_op     = ((funct3 == 3'b000) && funct7b5) ? ALU_SUB : f3_op;
    assign br_legal = (funct3 == 3'b000) || (funct3 == 3'b001);
    assign br_taken = (funct3 == 3'b000) ? zero : !zero;

    always_comb begin
        state_next        = state;
        reset_wire        = 1'b0;
        operacao          = ALU_PASS;
        ALU_SRC_A         = 2'b00;
        ALU_SRC_B         = 2'b00;
        WRITE_PC          = 1'b0;
        PC_SRC            = 1'b0;
        MEM_INSTR_RD      = 1'b0;
        WRITE_INSTRUCTION = 1'b0;
        WRITE_AB          = 1'b0;
        WRITE_ALUOUT      = 1'b0;
        MEM_DATA_RD       = 1'b0;
        MEM_DATA_WR       = 1'b0;
        WRITE_MDR         = 1'b0;
        REG_WRITE         = 1'b0;
        MEM_TO_REG        = 2'b00;
        trap              = 1'b0;

        case (state)
            S_RESET: begin
                reset_wire = 1'b1;
                state_next = S_FETCH;
            end
            S_FETCH: begin
                MEM_INSTR_RD = 1'b1;
                if (last) begin
                    WRITE_INSTRUCTION = 1'b1;
                    state_next        = S_DECODE;
                end
            end
            S_DECODE: begin
                // Precompute PC+imm into ALUOut as the branch/jump target.
                WRITE_AB     = 1'b1;
                ALU_SRC_A    = 2'b00;
                ALU_SRC_B    = 2'b10;
                operacao     = ALU_ADD;
                WRITE_ALUOUT = 1'b1;
                case (opcode)
                    OP_R:               state_next = S_EXEC_R;
                    OP_I:               state_next = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_next = S_ADDR;
                    OP_BRANCH:          state_next = S_BRANCH;
                    OP_JAL:             state_next = S_JAL;
                    OP_LUI:             state_next = S_LUI;
                    default:            state_next = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                if (f3_legal) begin
                    ALU_SRC_A    = 2'b01;
                    ALU_SRC_B    = 2'b00;
                    operacao     = r_op;
                    WRITE_ALUOUT = 1'b1;
                    state_next   = S_WB_ALU;
                end else begin
                    state_next = S_TRAP;
                end
            end
            S_EXEC_I: begin
                if (f3_legal) begin
                    ALU_SRC_A    = 2'b01;
                    ALU_SRC_B    = 2'b10;
                    operacao     = f3_op;
                    WRITE_ALUOUT = 1'b1;
                    state_next   = S_WB_ALU;
                end else begin
                    state_next = S_TRAP;
                end
            end
            S_ADDR: begin
                ALU_SRC_A    = 2'b01;
                ALU_SRC_B    = 2'b10;
                operacao     = ALU_ADD;
                WRITE_ALUOUT = 1'b1;
                state_next   = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                MEM_DATA_RD = 1'b1;
                if (last) begin
                    WRITE_MDR  = 1'b1;
                    state_next = S_WB_MEM;
                end
            end
            S_MEM_WRITE: begin
                MEM_DATA_WR = 1'b1;
                if (last) begin
                    state_next = S_PC_INC;
                end
            end
            S_WB_ALU: begin
                REG_WRITE  = 1'b1;
                MEM_TO_REG = 2'b00;
                state_next = S_PC_INC;
            end
            S_WB_MEM: begin
                REG_WRITE  = 1'b1;
                MEM_TO_REG = 2'b01;
                state_next = S_PC_INC;
            end
            S_LUI: begin
                REG_WRITE  = 1'b1;
                MEM_TO_REG = 2'b11;
                state_next = S_PC_INC;
            end
            S_BRANCH: begin
                if (br_legal) begin
                    ALU_SRC_A = 2'b01;
                    ALU_SRC_B = 2'b00;
                    operacao  = ALU_SUB;
                    if (br_taken) begin
                        WRITE_PC   = 1'b1;
                        PC_SRC     = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_PC_INC;
                    end
                end else begin
                    state_next = S_TRAP;
                end
            end
            S_JAL: begin
                // Link (old PC) and jump happen on the same edge.
                REG_WRITE  = 1'b1;
                MEM_TO_REG = 2'b10;
                WRITE_PC   = 1'b1;
                PC_SRC     = 1'b1;
                state_next = S_FETCH;
            end
            S_PC_INC: begin
                ALU_SRC_A  = 2'b00;
                ALU_SRC_B  = 2'b01;
                operacao   = ALU_ADD;
                WRITE_PC   = 1'b1;
                PC_SRC     = 1'b0;
                state_next = S_FETCH;
            end
            S_TRAP: begin
                trap       = 1'b1;
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_TRAP;
            end
        endcase
    end

    assign estado_atual = state;

endmodule

// File: tb/tb_controle_multiciclo.sv
// tb/tb_controle_multiciclo.sv - self-checking bench for controle_multiciclo
module tb_controle_multiciclo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'b0;
    logic [2:0] funct3 = 3'b0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;

    always #5 clk = ~clk;

    // Output word: {reset_wire, operacao, src_a, src_b, wpc, pc_src, ird, wir,
    //               wab, waluout, drd, dwr, wmdr, reg_write, mem_to_reg, trap}
    localparam logic [20:0] B_RST  = 21'h1 << 20;
    localparam logic [20:0] B_WPC  = 21'h1 << 12;
    localparam logic [20:0] B_PCS  = 21'h1 << 11;
    localparam logic [20:0] B_IRD  = 21'h1 << 10;
    localparam logic [20:0] B_WIR  = 21'h1 << 9;
    localparam logic [20:0] B_WAB  = 21'h1 << 8;
    localparam logic [20:0] B_WAO  = 21'h1 << 7;
    localparam logic [20:0] B_DRD  = 21'h1 << 6;
    localparam logic [20:0] B_DWR  = 21'h1 << 5;
    localparam logic [20:0] B_WMDR = 21'h1 << 4;
    localparam logic [20:0] B_RW   = 21'h1 << 3;
    localparam logic [20:0] B_TRAP = 21'h1;
    localparam logic [20:0] M_ALL  = 21'h1fffff;
    localparam logic [20:0] M_WR   = B_WPC | B_WIR | B_WAB | B_WAO | B_DRD | B_DWR | B_WMDR | B_RW;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    logic [20:0] obs_v [3];
    logic [3:0]  obs_s [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
        logic       reset_wire, write_pc, pc_src, instr_rd, write_instr, write_ab;
        logic       write_aluout, data_rd, data_wr, write_mdr, reg_write, trap;
        logic [2:0] operacao;
        logic [1:0] src_a, src_b, mem_to_reg;
        logic [3:0] estado;

        controle_multiciclo #(.MEM_LAT(LAT)) dut (
            .CLK(clk), .RST(rst), .opcode(opcode), .funct3(funct3),
            .funct7b5(funct7b5), .zero(zero), .reset_wire(reset_wire),
            .operacao(operacao), .ALU_SRC_A(src_a), .ALU_SRC_B(src_b),
            .WRITE_PC(write_pc), .PC_SRC(pc_src), .MEM_INSTR_RD(instr_rd),
            .WRITE_INSTRUCTION(write_instr), .WRITE_AB(write_ab),
            .WRITE_ALUOUT(write_aluout), .MEM_DATA_RD(data_rd),
            .MEM_DATA_WR(data_wr), .WRITE_MDR(write_mdr), .REG_WRITE(reg_write),
            .MEM_TO_REG(mem_to_reg), .trap(trap), .estado_atual(estado)
        );

        assign obs_v[g] = {reset_wire, operacao, src_a, src_b, write_pc, pc_src,
                           instr_rd, write_instr, write_ab, write_aluout, data_rd,
                           data_wr, write_mdr, reg_write, mem_to_reg, trap};
        assign obs_s[g] = estado;
    end

    typedef struct {
        string       tag;
        int          d;
        logic [3:0]  s;
        logic [20:0] v;
        logic [20:0] m;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [20:0] alu(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b);
        return {1'b0, op, a, b, 13'b0};
    endfunction

    function automatic logic [20:0] mtr(input logic [1:0] m);
        return {18'b0, m, 1'b0};
    endfunction

    task automatic push(input string tag, input int d, input logic [3:0] s,
                        input logic [20:0] v, input logic [20:0] m);
        exp_t e;
        e.tag = tag; e.d = d; e.s = s; e.v = v; e.m = m;
        sb.push_back(e);
    endtask

    task automatic check_head();
        exp_t e;
        e = sb.pop_front();
        total++;
        assert (obs_s[e.d] === e.s)
        else begin
            bad++;
            $error("FAIL %s state: got %0d want %0d", e.tag, obs_s[e.d], e.s);
        end
        total++;
        assert ((obs_v[e.d] & e.m) === (e.v & e.m))
        else begin
            bad++;
            $error("FAIL %s outputs: got %06h want %06h mask %06h", e.tag, obs_v[e.d], e.v, e.m);
        end
    endtask

    task automatic drain();
        while (sb.size() > 0) begin
            @(negedge clk);
            check_head();
        end
    endtask

    task automatic set_ins(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
        opcode = o; funct3 = f3; funct7b5 = f7; zero = z;
    endtask

    // RST high for 3 edges, released just after an edge so RESET spans a full cycle.
    task automatic do_reset(input string t, input int d);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        push({t, "_reset"}, d, 4'd0, B_RST, M_ALL);
    endtask

    task automatic push_fetch(input string t, input int d, input int lat);
        for (int i = 0; i < lat; i++)
            push({t, "_fetch"}, d, 4'd1, (i == lat - 1) ? (B_IRD | B_WIR) : B_IRD, M_ALL);
    endtask

    task automatic push_decode(input string t, input int d);
        push({t, "_decode"}, d, 4'd2, alu(3'b001, 2'b00, 2'b10) | B_WAB | B_WAO, M_ALL);
    endtask

    task automatic push_pcinc(input string t, input int d);
        push({t, "_pcinc"}, d, 4'd13, alu(3'b001, 2'b00, 2'b01) | B_WPC, M_ALL);
    endtask

    task automatic branch_case(input string t, input logic [2:0] f3, input logic z, input logic taken);
        set_ins(OP_BR, f3, 1'b0, z);
        do_reset(t, 0);
        push_fetch(t, 0, 1);
        push_decode(t, 0);
        if (taken) begin
            push({t, "_br"}, 0, 4'd10, alu(3'b010, 2'b01, 2'b00) | B_WPC | B_PCS, M_ALL);
        end else begin
            push({t, "_br"}, 0, 4'd10, alu(3'b010, 2'b01, 2'b00), M_ALL);
            push_pcinc(t, 0);
        end
        push({t, "_next"}, 0, 4'd1, B_IRD | B_WIR, M_ALL);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // R-type sub, MEM_LAT=1: states 1,2,3,8,13
        set_ins(OP_R, 3'b000, 1'b1, 1'b0);
        do_reset("rsub", 0);
        push_fetch("rsub", 0, 1);
        push_decode("rsub", 0);
        push("rsub_exec", 0, 4'd3, alu(3'b010, 2'b01, 2'b00) | B_WAO, M_ALL);
        push("rsub_wb", 0, 4'd8, B_RW | mtr(2'b00), M_ALL);
        push_pcinc("rsub", 0);
        push("rsub_next", 0, 4'd1, B_IRD | B_WIR, M_ALL);
        drain();

        // R-type slt
        set_ins(OP_R, 3'b010, 1'b0, 1'b0);
        do_reset("rslt", 0);
        push_fetch("rslt", 0, 1);
        push_decode("rslt", 0);
        push("rslt_exec", 0, 4'd3, alu(3'b110, 2'b01, 2'b00) | B_WAO, M_ALL);
        push("rslt_wb", 0, 4'd8, B_RW, M_ALL);
        drain();

        // I-type funct3 000 with funct7b5=1 is still add; xor via I-type too
        set_ins(OP_I, 3'b000, 1'b1, 1'b0);
        do_reset("addi", 0);
        push_fetch("addi", 0, 1);
        push_decode("addi", 0);
        push("addi_exec", 0, 4'd4, alu(3'b001, 2'b01, 2'b10) | B_WAO, M_ALL);
        push("addi_wb", 0, 4'd8, B_RW, M_ALL);
        push_pcinc("addi", 0);
        drain();

        set_ins(OP_I, 3'b100, 1'b0, 1'b0);
        do_reset("xori", 0);
        push_fetch("xori", 0, 1);
        push_decode("xori", 0);
        push("xori_exec", 0, 4'd4, alu(3'b101, 2'b01, 2'b10) | B_WAO, M_ALL);
        drain();

        // Load, MEM_LAT=3: 10 cycles from FETCH through PC_INC
        set_ins(OP_LD, 3'b011, 1'b0, 1'b0);
        do_reset("ld3", 1);
        push_fetch("ld3", 1, 3);
        push_decode("ld3", 1);
        push("ld3_addr", 1, 4'd5, alu(3'b001, 2'b01, 2'b10) | B_WAO, M_ALL);
        push("ld3_rd0", 1, 4'd6, B_DRD, M_ALL);
        push("ld3_rd1", 1, 4'd6, B_DRD, M_ALL);
        push("ld3_rd2", 1, 4'd6, B_DRD | B_WMDR, M_ALL);
        push("ld3_wb", 1, 4'd9, B_RW | mtr(2'b01), M_ALL);
        push_pcinc("ld3", 1);
        push("ld3_next", 1, 4'd1, B_IRD, M_ALL);
        drain();

        // Store, MEM_LAT=1
        set_ins(OP_ST, 3'b011, 1'b0, 1'b0);
        do_reset("st1", 0);
        push_fetch("st1", 0, 1);
        push_decode("st1", 0);
        push("st1_addr", 0, 4'd5, alu(3'b001, 2'b01, 2'b10) | B_WAO, M_ALL);
        push("st1_wr", 0, 4'd7, B_DWR, M_ALL);
        push_pcinc("st1", 0);
        push("st1_next", 0, 4'd1, B_IRD | B_WIR, M_ALL);
        drain();

        // Branches: beq/bne with both zero values
        branch_case("beq_z1", 3'b000, 1'b1, 1'b1);
        branch_case("beq_z0", 3'b000, 1'b0, 1'b0);
        branch_case("bne_z1", 3'b001, 1'b1, 1'b0);
        branch_case("bne_z0", 3'b001, 1'b0, 1'b1);

        // LUI and JAL
        set_ins(OP_LUI, 3'b000, 1'b0, 1'b0);
        do_reset("lui", 0);
        push_fetch("lui", 0, 1);
        push_decode("lui", 0);
        push("lui_wb", 0, 4'd12, B_RW | mtr(2'b11), M_ALL);
        push_pcinc("lui", 0);
        drain();

        set_ins(OP_JAL, 3'b000, 1'b0, 1'b0);
        do_reset("jal", 0);
        push_fetch("jal", 0, 1);
        push_decode("jal", 0);
        push("jal_exec", 0, 4'd11, B_RW | mtr(2'b10) | B_WPC | B_PCS, M_ALL);
        push("jal_next", 0, 4'd1, B_IRD | B_WIR, M_ALL);
        drain();

        // Illegal opcode: TRAP held 20 cycles with no strobes
        set_ins(7'b1111111, 3'b000, 1'b0, 1'b0);
        do_reset("ill", 0);
        push_fetch("ill", 0, 1);
        push_decode("ill", 0);
        for (int i = 0; i < 20; i++)
            push("ill_trap", 0, 4'd14, B_TRAP, M_ALL);
        drain();

        // R-type funct3 001: no writes in EXEC_R, then TRAP
        set_ins(OP_R, 3'b001, 1'b0, 1'b0);
        do_reset("rill", 0);
        push_fetch("rill", 0, 1);
        push_decode("rill", 0);
        push("rill_exec", 0, 4'd3, 21'h0, M_WR);
        for (int i = 0; i < 4; i++)
            push("rill_trap", 0, 4'd14, B_TRAP, M_ALL);
        drain();

        // Illegal branch funct3
        set_ins(OP_BR, 3'b010, 1'b0, 1'b1);
        do_reset("brill", 0);
        push_fetch("brill", 0, 1);
        push_decode("brill", 0);
        push("brill_br", 0, 4'd10, 21'h0, M_WR);
        push("brill_trap", 0, 4'd14, B_TRAP, M_ALL);
        drain();

        // Reset during 2nd cycle of MEM_WRITE, MEM_LAT=4
        set_ins(OP_ST, 3'b011, 1'b0, 1'b0);
        do_reset("mid", 2);
        push_fetch("mid", 2, 4);
        push_decode("mid", 2);
        push("mid_addr", 2, 4'd5, alu(3'b001, 2'b01, 2'b10) | B_WAO, M_ALL);
        push("mid_wr0", 2, 4'd7, B_DWR, M_ALL);
        push("mid_wr1", 2, 4'd7, B_DWR, M_ALL);
        drain();
        #1 rst = 1'b1;
        #1;
        push("mid_async", 2, 4'd0, B_RST, M_ALL);
        check_head();
        @(posedge clk);
        #1 rst = 1'b0;
        push("mid_reset", 2, 4'd0, B_RST, M_ALL);
        push_fetch("mid_re", 2, 4);
        push_decode("mid_re", 2);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
